// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: instruction RAM address/data plus the valid/ready
// handoff of decoded instructions to the control unit.
interface instr_fetch_unit_if #(
  parameter int ADDR_W  = 9,
  parameter int INSTR_W = 16,
  parameter int OPC_W   = 6
);
  localparam int OPR_W = INSTR_W - OPC_W;

  logic [ADDR_W-1:0]  address;
  logic [INSTR_W-1:0] instr_in;
  logic               ir_valid;
  logic               ir_ready;
  logic               branch_take;
  logic [OPC_W-1:0]   opcode;
  logic [OPR_W-1:0]   operand;
  logic [ADDR_W-1:0]  pc_out;

  modport master (
    output address, ir_valid, opcode, operand, pc_out,
    input  instr_in, ir_ready, branch_take
  );

  modport slave (
    input  address, ir_valid, opcode, operand, pc_out,
    output instr_in, ir_ready, branch_take
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, captures RAM words into IR and hands
// them over with valid/ready. FETCH_RETIRE_CNT_EN adds a retired-instruction counter.
module instr_fetch_unit #(
  parameter int ADDR_W     = 9,
  parameter int INSTR_W    = 16,
  parameter int OPC_W      = 6,
  parameter int INST_DEPTH = 166,
  parameter int START_ADDR = 0,
  parameter int NOP_OP     = 46
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  instr_fetch_unit_if.master bus,
  output logic               halted,
  output logic               addr_err
`ifdef FETCH_RETIRE_CNT_EN
  , output logic [15:0]      retired_cnt
`endif
);

  localparam int OPR_W = INSTR_W - OPC_W;
  localparam logic [ADDR_W-1:0] START_PC = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] LAST_PC  = ADDR_W'(INST_DEPTH - 1);
  localparam logic [OPR_W-1:0]  DEPTH_OP = OPR_W'(INST_DEPTH);
  localparam logic [OPC_W-1:0]  NOP_OPC  = OPC_W'(NOP_OP);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_VALID,
    S_HALT
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  pc_out_q, pc_out_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               halted_q, halted_d;
  logic               err_q, err_d;
  logic               handshake;
  logic [OPC_W-1:0]   ir_opc;
  logic [OPR_W-1:0]   ir_opr;
`ifdef FETCH_RETIRE_CNT_EN
  logic [15:0]        cnt_q, cnt_d;
`endif

  assign ir_opc = ir_q[INSTR_W-1:OPR_W];
  assign ir_opr = ir_q[OPR_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      pc_out_q <= '0;
      ir_q     <= '0;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
`ifdef FETCH_RETIRE_CNT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pc_out_q <= pc_out_d;
      ir_q     <= ir_d;
      halted_q <= halted_d;
      err_q    <= err_d;
`ifdef FETCH_RETIRE_CNT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pc_out_d  = pc_out_q;
    ir_d      = ir_q;
    halted_d  = halted_q;
    err_d     = err_q;
    handshake = 1'b0;
`ifdef FETCH_RETIRE_CNT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_d  = S_FETCH;
          pc_d     = START_PC;
          halted_d = 1'b0;
          err_d    = 1'b0;
`ifdef FETCH_RETIRE_CNT_EN
          cnt_d    = '0;
`endif
        end
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        ir_d     = bus.instr_in;
        pc_out_d = pc_q;
        state_d  = S_VALID;
      end
      S_VALID: begin
        if (bus.ir_ready) begin
          handshake = 1'b1;
          // Priority: NOP halt, bad branch target, branch, end of memory, step.
          if (ir_opc == NOP_OPC) begin
            state_d  = S_HALT;
            halted_d = 1'b1;
          end else if (bus.branch_take) begin
            if (ir_opr >= DEPTH_OP) begin
              state_d  = S_HALT;
              halted_d = 1'b1;
              err_d    = 1'b1;
            end else begin
              pc_d    = ir_opr[ADDR_W-1:0];
              state_d = S_FETCH;
            end
          end else if (pc_q == LAST_PC) begin
            state_d  = S_HALT;
            halted_d = 1'b1;
            err_d    = 1'b1;
          end else begin
            pc_d    = pc_q + ADDR_W'(1);
            state_d = S_FETCH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
`ifdef FETCH_RETIRE_CNT_EN
    if (handshake && (cnt_q != '1)) begin
      cnt_d = cnt_q + 16'd1;
    end
`endif
  end

  always_comb begin
    bus.ir_valid = (state_q == S_VALID);
  end

  assign bus.address = pc_q;
  assign bus.opcode  = ir_opc;
  assign bus.operand = ir_opr;
  assign bus.pc_out  = pc_out_q;
  assign halted      = halted_q;
  assign addr_err    = err_q;
`ifdef FETCH_RETIRE_CNT_EN
  assign retired_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a program-walk model predicts each
// fetched instruction; a negedge monitor compares and retires predictions.
module tb_instr_fetch_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic halted, addr_err;
`ifdef FETCH_RETIRE_CNT_EN
  logic [15:0] retired_cnt;
`endif
  logic ready = 1'b1;
  logic bt = 1'b0;
  logic [15:0] ram [512];
  logic [15:0] ram_q = '0;

  instr_fetch_unit_if #(.ADDR_W(9), .INSTR_W(16), .OPC_W(6)) bus ();

  assign bus.instr_in    = ram_q;
  assign bus.ir_ready    = ready;
  assign bus.branch_take = bt;

  instr_fetch_unit #(
    .ADDR_W(9), .INSTR_W(16), .OPC_W(6),
    .INST_DEPTH(166), .START_ADDR(0), .NOP_OP(46)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .bus(bus),
    .halted(halted),
    .addr_err(addr_err)
`ifdef FETCH_RETIRE_CNT_EN
    , .retired_cnt(retired_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Instruction RAM with one-cycle registered read
  always @(posedge clk) ram_q <= ram[bus.address];

  typedef struct {
    logic [8:0]  pc;
    logic [15:0] w;
  } item_t;

  item_t q[$];
  int cyc = 0;
  int ev_cyc = 0;
  bit exp_idle = 1'b1;
  bit exp_halt = 1'b0;
  bit exp_err = 1'b0;
  logic [8:0] exp_addr = '0;
  int exp_cnt = 0;
  int visits[512];
  int errors = 0;
  int checks = 0;
  int mode = 0;
  int hold56 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic void push(input logic [8:0] pc);
    item_t it;
    it.pc = pc;
    it.w  = ram[pc];
    q.push_back(it);
    ev_cyc = cyc + 1;
    visits[pc]++;
  endfunction

  function automatic logic [15:0] rand_word(input bit allow_nop);
    logic [5:0] opc;
    logic [9:0] opr;
    opc = 6'($urandom_range(0, 63));
    if (opc == 6'd46 && !allow_nop) opc = 6'd45;
    if (allow_nop && $urandom_range(0, 39) == 0) opc = 6'd46;
    if ($urandom_range(0, 9) == 0) opr = 10'($urandom_range(166, 1023));
    else opr = 10'($urandom_range(0, 165));
    return {opc, opr};
  endfunction

  // Monitor / reference model
  always @(negedge clk) begin
    item_t it;
    bit ev;
    logic [5:0] opc;
    logic [9:0] opr;
    if (!rst_n) begin
      chk("rst_address", 32'(bus.address), 0);
      chk("rst_ir_valid", 32'(bus.ir_valid), 0);
      chk("rst_opcode", 32'(bus.opcode), 0);
      chk("rst_operand", 32'(bus.operand), 0);
      chk("rst_pc_out", 32'(bus.pc_out), 0);
      chk("rst_halted", 32'(halted), 0);
      chk("rst_addr_err", 32'(addr_err), 0);
      q.delete();
      exp_idle = 1'b1;
      exp_halt = 1'b0;
      exp_err  = 1'b0;
      exp_addr = '0;
      exp_cnt  = 0;
    end else begin
      chk("halted", 32'(halted), 32'(exp_halt));
      chk("addr_err", 32'(addr_err), 32'(exp_err));
`ifdef FETCH_RETIRE_CNT_EN
      chk("retired_cnt", 32'(retired_cnt), 32'(exp_cnt));
`endif
      if (q.size() != 0) begin
        ev = (cyc - ev_cyc) >= 2;
        chk("ir_valid", 32'(bus.ir_valid), 32'(ev));
        chk("address", 32'(bus.address), 32'(q[0].pc));
        if (ev) begin
          chk("opcode", 32'(bus.opcode), 32'(q[0].w[15:10]));
          chk("operand", 32'(bus.operand), 32'(q[0].w[9:0]));
          chk("pc_out", 32'(bus.pc_out), 32'(q[0].pc));
          if (ready) begin
            it  = q.pop_front();
            opc = it.w[15:10];
            opr = it.w[9:0];
            exp_cnt = (exp_cnt == 65535) ? 65535 : exp_cnt + 1;
            exp_addr = it.pc;
            if (opc == 6'd46) begin
              exp_idle = 1'b1; exp_halt = 1'b1;
            end else if (bt && int'(opr) >= 166) begin
              exp_idle = 1'b1; exp_halt = 1'b1; exp_err = 1'b1;
            end else if (bt) begin
              push(opr[8:0]);
            end else if (it.pc == 9'd165) begin
              exp_idle = 1'b1; exp_halt = 1'b1; exp_err = 1'b1;
            end else begin
              push(it.pc + 9'd1);
            end
          end
        end
      end else begin
        chk("ir_valid_idle", 32'(bus.ir_valid), 0);
        chk("address_idle", 32'(bus.address), 32'(exp_addr));
        if (start && exp_idle) begin
          exp_idle = 1'b0;
          exp_halt = 1'b0;
          exp_err  = 1'b0;
          exp_cnt  = 0;
          push(9'd0);
        end
      end
    end
  end

  // Control-unit behaviour per phase, applied just after each rising edge
  task automatic drive_ctrl();
    bit f;
    bit inval;
    logic [8:0] fpc;
    f     = (q.size() != 0);
    fpc   = f ? q[0].pc : 9'd0;
    inval = f && ((cyc - ev_cyc) >= 2);
    case (mode)
      0: begin
        ready = !(f && fpc == 9'd56 && hold56 < 5);
        if (!ready && inval) hold56++;
        bt = f && fpc == 9'd163 && visits[163] == 1;
      end
      1: begin ready = 1'b1; bt = f && fpc == 9'd5; end
      2: begin ready = ($urandom_range(0, 2) != 0); bt = 1'b0; end
      3: begin
        ready = ($urandom_range(0, 3) != 0);
        bt    = ($urandom_range(0, 3) == 0);
        start = ($urandom_range(0, 7) == 0);
      end
      default: begin ready = 1'b1; bt = 1'b0; end
    endcase
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    drive_ctrl();
  endtask

  task automatic start_pulse();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic run_until_halt(input int budget, input string nm);
    int n = 0;
    while (!(exp_halt && q.size() == 0) && n < budget) begin
      cycle();
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s_timeout: no halt within %0d cycles, expected halt", nm, budget);
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) ram[i] = rand_word(1'b0);
    ram[0]   = {6'd0, 10'd0};
    ram[1]   = {6'd2, 10'd0};
    ram[2]   = {6'd3, 10'd0};
    ram[56]  = {6'd19, 10'd30};
    ram[163] = {6'd47, 10'd63};
    ram[164] = {6'd46, 10'd0};

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    cycle();

    // Sequential walk, ready hold at 56, branch then fall-through at 163, NOP halt at 164
    mode = 0;
    hold56 = 0;
    for (int i = 0; i < 512; i++) visits[i] = 0;
    start_pulse();
    run_until_halt(2000, "A");
    chk("A_halted", 32'(halted), 1);
    chk("A_addr_err", 32'(addr_err), 0);
    chk("A_address", 32'(bus.address), 164);
    chk("A_hold_cycles", hold56, 5);

    // Branch to out-of-range target
    ram[5] = {6'd7, 10'd900};
    mode = 1;
    start_pulse();
    run_until_halt(200, "B");
    chk("B_halted", 32'(halted), 1);
    chk("B_addr_err", 32'(addr_err), 1);
    chk("B_address", 32'(bus.address), 5);
`ifdef FETCH_RETIRE_CNT_EN
    chk("B_retired_cnt", 32'(retired_cnt), 6);
`endif

    // Sequential step beyond the last instruction
    ram[5]   = {6'd7, 10'd12};
    ram[164] = {6'd1, 10'd0};
    mode = 2;
    start_pulse();
    run_until_halt(3000, "C");
    chk("C_halted", 32'(halted), 1);
    chk("C_addr_err", 32'(addr_err), 1);
    chk("C_address", 32'(bus.address), 165);

    // Reset asserted while the fetch of pc 10 is in WAIT
    ram[9] = {6'd33, 10'd77};
    mode = 4;
    start_pulse();
    begin
      int n = 0;
      while (!(q.size() != 0 && q[0].pc == 9'd10 && (cyc - ev_cyc) == 1) && n < 200) begin
        cycle();
        n++;
      end
      checks++;
      if (n >= 200) begin
        errors++;
        $display("FAIL D_reach_wait: pc 10 WAIT not reached, expected within 200 cycles");
      end
    end
    rst_n = 1'b0;
    #1;
    chk("D_address", 32'(bus.address), 0);
    chk("D_ir_valid", 32'(bus.ir_valid), 0);
    chk("D_opcode", 32'(bus.opcode), 0);
    chk("D_pc_out", 32'(bus.pc_out), 0);
    cycle();
    cycle();
    rst_n = 1'b1;
    repeat (6) cycle();
    chk("D_idle_valid", 32'(bus.ir_valid), 0);
    chk("D_idle_address", 32'(bus.address), 0);

    // Randomized program, handshakes, branches and restarts
    for (int i = 0; i < 512; i++) ram[i] = rand_word(1'b1);
    mode = 3;
    repeat (6000) cycle();
    mode = 4;
    start = 1'b0;
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
